// File: rtl/cfg_pkg.sv
// Shared state encoding and default sizing for the configuration frame chain.
package cfg_pkg;

  localparam int CFG_DATA_W_DEF = 32;
  localparam int CFG_FRAMES_DEF = 83;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    FULL     = 2'd2,
    READBACK = 2'd3
  } cfg_state_t;

endpackage

// File: rtl/cfg_skid.sv
// One-entry valid/ready register that drives the downstream config word.
// Data is held stable while out_vld_o is waiting for out_rdy_i.
module cfg_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;

  assign in_rdy_o   = !r_full || out_rdy_i;
  assign out_vld_o  = r_full;
  assign out_data_o = r_data;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (flush_i) begin
      r_full <= 1'b0;
    end else if (in_vld_i && in_rdy_o) begin
      r_full <= 1'b1;
      r_data <= in_data_i;
    end else if (out_rdy_i) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/cfg_frame_chain.sv
// Per-slice configuration frame loader: fills a shadow store, forwards surplus
// words down the chain, and copies shadow to active on commit. CFG_READBACK_EN adds readback.
module cfg_frame_chain
  import cfg_pkg::*;
#(
  parameter int DATA_W = CFG_DATA_W_DEF,
  parameter int FRAMES = CFG_FRAMES_DEF
) (
  input  logic                     clk,
  input  logic                     nres,
  input  logic [DATA_W-1:0]        cfg_i,
  input  logic                     cfg_vld_i,
  output logic                     cfg_rdy_o,
  output logic [DATA_W-1:0]        cfg_o,
  output logic                     cfg_vld_o,
  input  logic                     cfg_rdy_i,
  input  logic                     load_i,
  output logic                     load_o,
  input  logic                     commit_i,
  output logic                     commit_o,
  input  logic                     rb_i,
  output logic [DATA_W*FRAMES-1:0] active_o,
  output logic                     busy_o,
  output logic                     full_o,
  output logic                     err_o
);

  localparam int CNT_W = $clog2(FRAMES + 1);
  localparam int IDX_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES);

  cfg_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_inc;
  logic [DATA_W-1:0] r_shadow [FRAMES];
  logic [DATA_W-1:0] r_active [FRAMES];
  logic              r_load_d, r_commit_d, r_err;

  logic              w_fill_acc, w_commit, w_err_set, w_flush;
  logic              w_rb_req, w_rb_enter;
  logic              w_skid_in_vld, w_skid_in_rdy, w_skid_out_vld;
  logic [DATA_W-1:0] w_skid_in_data;

  assign w_count_inc = r_count + 1'b1;

`ifdef CFG_READBACK_EN
  logic [CNT_W-1:0]  r_rb_idx;
  cfg_state_t        r_rb_ret;
  logic              r_rb_pend;
  logic [DATA_W-1:0] w_rb_data;

  assign w_rb_req  = rb_i || r_rb_pend;
  assign w_rb_data = r_active[r_rb_idx[IDX_W-1:0]];
`else
  logic w_unused_rb;

  assign w_rb_req    = 1'b0;
  assign w_unused_rb = rb_i;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_fill_acc     = 1'b0;
    w_commit       = 1'b0;
    w_err_set      = 1'b0;
    w_flush        = 1'b0;
    w_rb_enter     = 1'b0;
    cfg_rdy_o      = 1'b0;
    w_skid_in_vld  = 1'b0;
    w_skid_in_data = cfg_i;
    unique case (r_state)
      IDLE: begin
        w_err_set  = commit_i;
        w_rb_enter = w_rb_req && !w_skid_out_vld;
      end
      FILL: begin
        cfg_rdy_o  = 1'b1;
        w_err_set  = commit_i;
        w_fill_acc = cfg_vld_i && !load_i && (r_count != LAST_CNT);
        if (w_fill_acc && (w_count_inc == LAST_CNT)) w_state_nxt = FULL;
      end
      FULL: begin
        w_commit      = commit_i;
        cfg_rdy_o     = w_skid_in_rdy && !w_rb_req;
        w_skid_in_vld = cfg_vld_i && !load_i && !w_rb_req;
        w_rb_enter    = w_rb_req && !w_skid_out_vld;
      end
`ifdef CFG_READBACK_EN
      READBACK: begin
        w_err_set      = load_i || commit_i;
        w_skid_in_data = w_rb_data;
        w_skid_in_vld  = (r_rb_idx != LAST_CNT);
        if ((r_rb_idx == LAST_CNT) && w_skid_out_vld && cfg_rdy_i) w_state_nxt = r_rb_ret;
      end
`endif
      default: ;
    endcase
    if (w_rb_enter) w_state_nxt = READBACK;
    // A new load pre-empts everything except an in-flight readback.
    if (load_i && (r_state != READBACK)) begin
      w_state_nxt = FILL;
      w_flush     = 1'b1;
      w_rb_enter  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_load_d   <= 1'b0;
      r_commit_d <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_load_d   <= load_i;
      r_commit_d <= commit_i;
      if (w_err_set) r_err <= 1'b1;
      if (w_flush) r_count <= '0;
      else if (w_fill_acc) r_count <= w_count_inc;
    end
  end

  // NOTE: both frame stores are reset so the fabric sees an all-zero configuration after nres.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      for (int k = 0; k < FRAMES; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (w_fill_acc) r_shadow[r_count[IDX_W-1:0]] <= cfg_i;
      if (w_commit) r_active <= r_shadow;
    end
  end

`ifdef CFG_READBACK_EN
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_rb_idx  <= '0;
      r_rb_ret  <= IDLE;
      r_rb_pend <= 1'b0;
    end else begin
      if (w_flush) begin
        r_rb_pend <= 1'b0;
      end else if (w_rb_enter) begin
        r_rb_pend <= 1'b0;
        r_rb_idx  <= '0;
        r_rb_ret  <= r_state;
      end else if (rb_i && ((r_state == IDLE) || (r_state == FULL))) begin
        r_rb_pend <= 1'b1;
      end
      if ((r_state == READBACK) && w_skid_in_vld && w_skid_in_rdy) r_rb_idx <= w_count_rb_inc(r_rb_idx);
    end
  end

  function automatic logic [CNT_W-1:0] w_count_rb_inc(input logic [CNT_W-1:0] idx);
    return idx + 1'b1;
  endfunction
`endif

  cfg_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk       (clk),
    .nres      (nres),
    .flush_i   (w_flush),
    .in_data_i (w_skid_in_data),
    .in_vld_i  (w_skid_in_vld),
    .in_rdy_o  (w_skid_in_rdy),
    .out_data_o(cfg_o),
    .out_vld_o (w_skid_out_vld),
    .out_rdy_i (cfg_rdy_i)
  );

  for (genvar k = 0; k < FRAMES; k++) begin : g_active
    assign active_o[k*DATA_W +: DATA_W] = r_active[k];
  end

  assign cfg_vld_o = w_skid_out_vld;
  assign load_o    = r_load_d;
  assign commit_o  = r_commit_d;
  assign busy_o    = (r_state == FILL);
  assign full_o    = (r_state == FULL);
  assign err_o     = r_err;

endmodule

// File: tb/tb_cfg_frame_chain.sv
// Directed bench: an 83-frame slice for fill/commit/forward/error cases and a
// two-slice 4-frame chain for propagation and (with CFG_READBACK_EN) readback.
module tb_cfg_frame_chain;

  localparam int DW  = 32;
  localparam int FR  = 83;
  localparam int CDW = 8;
  localparam int CFR = 4;

  logic clk = 1'b0;
  logic nres;
  always #5 clk = ~clk;

  logic [DW-1:0]    cfg_i, cfg_o;
  logic             cfg_vld_i, cfg_rdy_o, cfg_vld_o, cfg_rdy_i;
  logic             load_i, load_o, commit_i, commit_o, rb_i;
  logic [DW*FR-1:0] active_o;
  logic             busy_o, full_o, err_o;

  logic [CDW-1:0]     a_cfg_i, ab_data, b_cfg_o;
  logic               a_vld_i, a_rdy_o, ab_vld, ab_rdy, b_vld_o, end_rdy;
  logic               a_load, ab_load, b_load_o, a_commit, ab_commit, b_commit_o;
  logic               a_rb, b_rb;
  logic [CDW*CFR-1:0] a_act, b_act;
  logic               a_busy, a_full, a_err, b_busy, b_full, b_err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          vld;
    logic          rdy;
    logic          exp_rdy_o;
    logic          exp_vld_o;
    logic [DW-1:0] exp_cfg_o;
  } fwd_vec_t;

  fwd_vec_t         fwd_tab [9];
  logic [DW*FR-1:0] exp_act;

  cfg_frame_chain #(.DATA_W(DW), .FRAMES(FR)) u_dut (
    .clk(clk), .nres(nres), .cfg_i(cfg_i), .cfg_vld_i(cfg_vld_i), .cfg_rdy_o(cfg_rdy_o),
    .cfg_o(cfg_o), .cfg_vld_o(cfg_vld_o), .cfg_rdy_i(cfg_rdy_i), .load_i(load_i),
    .load_o(load_o), .commit_i(commit_i), .commit_o(commit_o), .rb_i(rb_i),
    .active_o(active_o), .busy_o(busy_o), .full_o(full_o), .err_o(err_o)
  );

  cfg_frame_chain #(.DATA_W(CDW), .FRAMES(CFR)) u_slice_a (
    .clk(clk), .nres(nres), .cfg_i(a_cfg_i), .cfg_vld_i(a_vld_i), .cfg_rdy_o(a_rdy_o),
    .cfg_o(ab_data), .cfg_vld_o(ab_vld), .cfg_rdy_i(ab_rdy), .load_i(a_load),
    .load_o(ab_load), .commit_i(a_commit), .commit_o(ab_commit), .rb_i(a_rb),
    .active_o(a_act), .busy_o(a_busy), .full_o(a_full), .err_o(a_err)
  );

  cfg_frame_chain #(.DATA_W(CDW), .FRAMES(CFR)) u_slice_b (
    .clk(clk), .nres(nres), .cfg_i(ab_data), .cfg_vld_i(ab_vld), .cfg_rdy_o(ab_rdy),
    .cfg_o(b_cfg_o), .cfg_vld_o(b_vld_o), .cfg_rdy_i(end_rdy), .load_i(ab_load),
    .load_o(b_load_o), .commit_i(ab_commit), .commit_o(b_commit_o), .rb_i(b_rb),
    .active_o(b_act), .busy_o(b_busy), .full_o(b_full), .err_o(b_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_active(input string name, input logic [DW*FR-1:0] exp);
    int bad = -1;
    for (int k = 0; k < FR; k++)
      if (bad < 0 && active_o[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: frame %0d got 0x%0h expected 0x%0h", name, bad,
               active_o[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int timeouts;
    logic [CDW-1:0] rb_got [$];

    fwd_tab[0] = '{32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5};
    fwd_tab[1] = '{32'h5A5A5A5A, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5};
    fwd_tab[2] = '{32'h5A5A5A5A, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5};
    fwd_tab[3] = '{32'h5A5A5A5A, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5};
    fwd_tab[4] = '{32'h5A5A5A5A, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5A5A5A5A};
    fwd_tab[5] = '{32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000};
    fwd_tab[6] = '{32'h11111111, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11111111};
    fwd_tab[7] = '{32'h22222222, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22222222};
    fwd_tab[8] = '{32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000};
    for (int k = 0; k < FR; k++) exp_act[k*DW +: DW] = DW'(k);

    nres = 1'b1;
    cfg_i = '0; cfg_vld_i = 1'b0; cfg_rdy_i = 1'b0;
    load_i = 1'b0; commit_i = 1'b0; rb_i = 1'b0;
    a_cfg_i = '0; a_vld_i = 1'b0; end_rdy = 1'b1;
    a_load = 1'b0; a_commit = 1'b0; a_rb = 1'b0; b_rb = 1'b0;

    // Reset values.
    #2 nres = 1'b0;
    #10;
    check("reset_flags", {57'd0, cfg_rdy_o, cfg_vld_o, load_o, commit_o, busy_o, full_o, err_o}, 64'd0);
    check("reset_cfg_o", cfg_o, 0);
    check_active("reset_active", '0);
    nres = 1'b1;

    // Load and fill all 83 frames with 0..82.
    step();
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    check("load_busy", busy_o, 1);
    check("load_o_pulse", load_o, 1);
    for (int k = 0; k < FR; k++) begin
      cfg_i = DW'(k);
      cfg_vld_i = 1'b1;
      #1;
      check("fill_rdy", cfg_rdy_o, 1);
      check("fill_busy", busy_o, 1);
      if (k == 1) check("load_o_drop", load_o, 0);
      step();
    end
    cfg_vld_i = 1'b0;
    check("fill_full", full_o, 1);
    check("fill_not_busy", busy_o, 0);
    check_active("fill_active_untouched", '0);

    // Commit makes the shadow visible one cycle later.
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    check("commit_frame5", active_o[5*DW +: DW], 5);
    check("commit_frame82", active_o[82*DW +: DW], 82);
    check_active("commit_all", exp_act);
    check("commit_o_pulse", commit_o, 1);
    step();
    check("commit_o_drop", commit_o, 0);

    // Forwarding through the skid register, including a 3-cycle downstream stall.
    for (int i = 0; i < 9; i++) begin
      cfg_i = fwd_tab[i].data;
      cfg_vld_i = fwd_tab[i].vld;
      cfg_rdy_i = fwd_tab[i].rdy;
      #1;
      check($sformatf("fwd%0d_rdy_o", i), cfg_rdy_o, fwd_tab[i].exp_rdy_o);
      step();
      check($sformatf("fwd%0d_vld_o", i), cfg_vld_o, fwd_tab[i].exp_vld_o);
      if (fwd_tab[i].exp_vld_o) check($sformatf("fwd%0d_cfg_o", i), cfg_o, fwd_tab[i].exp_cfg_o);
    end
    check("fwd_still_full", full_o, 1);

    // Commit alongside a forwarded word uses the untouched shadow.
    cfg_i = 32'hDEADBEEF; cfg_vld_i = 1'b1; cfg_rdy_i = 1'b1; commit_i = 1'b1;
    step();
    cfg_vld_i = 1'b0; commit_i = 1'b0;
    check_active("commit_during_fwd", exp_act);
    check("commit_fwd_cfg_o", cfg_o, 32'hDEADBEEF);
    check("commit_fwd_err", err_o, 0);
    step();

    // Commit in FILL at count 10: ignored, sticky error.
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cfg_i = 32'h100 + DW'(k);
      cfg_vld_i = 1'b1;
      step();
    end
    cfg_vld_i = 1'b0;
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    check("fill_commit_err", err_o, 1);
    check("fill_commit_busy", busy_o, 1);
    check_active("fill_commit_active", exp_act);
    repeat (3) step();
    check("err_sticky", err_o, 1);

    // Asynchronous reset mid-FILL.
    nres = 1'b0;
    #2;
    check("rst_err", err_o, 0);
    check("rst_busy_full", {busy_o, full_o}, 0);
    check_active("rst_active", '0);
    nres = 1'b1;
    step();

    // Two chained 4-frame slices, words 1..8.
    a_load = 1'b1;
    step();
    a_load = 1'b0;
    timeouts = 0;
    for (int w = 1; w <= 8; w++) begin
      a_cfg_i = CDW'(w);
      a_vld_i = 1'b1;
      #1;
      n = 0;
      while (!a_rdy_o && n < 20) begin
        step();
        n++;
      end
      if (n >= 20) timeouts++;
      step();
    end
    a_vld_i = 1'b0;
    check("chain_send_timeout", timeouts, 0);
    n = 0;
    while (!b_full && n < 20) begin
      step();
      n++;
    end
    check("chain_b_full", b_full, 1);
    check("chain_a_full", a_full, 1);
    a_commit = 1'b1;
    step();
    a_commit = 1'b0;
    step();
    step();
    check("chain_a_active", a_act, 32'h04030201);
    check("chain_b_active", b_act, 32'h08070605);
    check("chain_errs", {a_err, b_err}, 0);

`ifdef CFG_READBACK_EN
    // Readback of slice A's active frames with random downstream stalls.
    a_rb = 1'b1;
    step();
    a_rb = 1'b0;
    check("rb_rdy_low", a_rdy_o, 0);
    n = 0;
    while (rb_got.size() < CFR && n < 200) begin
      end_rdy = 1'($urandom_range(0, 1));
      #1;
      if (ab_vld && ab_rdy) rb_got.push_back(ab_data);
      step();
      n++;
    end
    end_rdy = 1'b1;
    check("rb_count", rb_got.size(), CFR);
    for (int i = 0; i < rb_got.size(); i++) check($sformatf("rb_word%0d", i), rb_got[i], i + 1);
    n = 0;
    while (!a_full && n < 20) begin
      step();
      n++;
    end
    check("rb_return_full", a_full, 1);
    check("rb_no_err", a_err, 0);
`else
    // Without readback, rb_i has no effect.
    a_rb = 1'b1;
    step();
    a_rb = 1'b0;
    repeat (3) begin
      check("rb_ignored_vld", ab_vld, 0);
      step();
    end
    check("rb_ignored_full", a_full, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
